issue_ctrl: RTL and testbench

//   Issue controller between decode and execute of the RV64 core. Holds a 32-entry register

---
 rtl/issue_ctrl_if.sv | 41 ++++
 rtl/issue_ctrl.sv | 97 +++++++++
 tb/tb_issue_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_ctrl_if.sv
// Decode/execute/writeback side of the issue controller, bundled as one interface.
// The master modport is the pipeline driving the controller; the slave modport is issue_ctrl itself.
interface issue_ctrl_if #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic            id_valid;
  logic            id_rs1_ena;
  logic [AW-1:0]   id_rs1_addr;
  logic            id_rs2_ena;
  logic [AW-1:0]   id_rs2_addr;
  logic            id_rd_ena;
  logic [AW-1:0]   id_rd_addr;
  logic            id_is_bj;
  logic            id_is_term;
  logic            mem_busy;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd_addr;
  logic            ex_bj_valid;
  logic            ex_bj_taken;
  logic            id_ready;
  logic            flush;
  logic            halt;
  logic [NREG-1:0] sb_pending;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
           id_rd_ena, id_rd_addr, id_is_bj, id_is_term, mem_busy,
           wb_valid, wb_rd_addr, ex_bj_valid, ex_bj_taken,
    input  id_ready, flush, halt, sb_pending, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
           id_rd_ena, id_rd_addr, id_is_bj, id_is_term, mem_busy,
           wb_valid, wb_rd_addr, ex_bj_valid, ex_bj_taken,
    output id_ready, flush, halt, sb_pending, stall_cnt
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue controller: register scoreboard for RAW/WAW hazards, branch serialisation with
// redirect flush, drain-and-halt on the termination opcode, and a saturating stall counter.
module issue_ctrl #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_DRAIN, S_HALT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREG-1:0]  r_sb;
  logic [NREG-1:0]  w_sb_set;
  logic [NREG-1:0]  w_sb_clr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hazard;
  logic             w_ready;
  logic             w_flush;
  logic             w_halt;
  logic             w_issue;

  assign w_hazard = (bus.id_rs1_ena && (bus.id_rs1_addr != '0) && r_sb[bus.id_rs1_addr]) ||
                    (bus.id_rs2_ena && (bus.id_rs2_addr != '0) && r_sb[bus.id_rs2_addr]) ||
                    (bus.id_rd_ena  && (bus.id_rd_addr  != '0) && r_sb[bus.id_rd_addr]);
  assign w_issue  = bus.id_valid && w_ready;

  // State register.
  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_issue && bus.id_is_term)    w_state_nxt = S_DRAIN;
        else if (w_issue && bus.id_is_bj) w_state_nxt = S_BR_WAIT;
      end
      S_BR_WAIT: if (bus.ex_bj_valid) w_state_nxt = S_RUN;
      S_DRAIN:   if ((r_sb == '0) && !bus.mem_busy) w_state_nxt = S_HALT;
      S_HALT:    w_state_nxt = S_HALT;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  // Output logic. id_ready is qualified by rst_n so it reads 0 while reset is held,
  // even though the state register already shows RUN.
  always_comb begin
    w_ready = 1'b0;
    w_flush = 1'b0;
    w_halt  = 1'b0;
    unique case (r_state)
      S_RUN:     w_ready = rst_n && !bus.mem_busy && !w_hazard;
      S_BR_WAIT: w_flush = bus.ex_bj_valid && bus.ex_bj_taken;
      S_DRAIN:   w_ready = 1'b0;
      S_HALT:    w_halt  = 1'b1;
      default:   w_ready = 1'b0;
    endcase
  end

  // Scoreboard: set on issue of a writer, clear on writeback; set wins. x0 is never targeted.
  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (w_issue && bus.id_rd_ena && (bus.id_rd_addr != '0)) w_sb_set[bus.id_rd_addr] = 1'b1;
    if (bus.wb_valid && (bus.wb_rd_addr != '0))             w_sb_clr[bus.wb_rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb <= '0;
    else        r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && bus.id_valid && !w_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.id_ready   = w_ready;
  assign bus.flush      = w_flush;
  assign bus.halt       = w_halt;
  assign bus.sb_pending = r_sb;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hazards, x0, branch flush, set/clear priority, drain-halt,
// mid-branch reset, and counter saturation on a narrow-counter instance.
module tb_issue_ctrl;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  issue_ctrl_if #(.NREG(32), .AW(5), .CNT_W(32)) bus ();
  issue_ctrl_if #(.NREG(32), .AW(5), .CNT_W(4))  b4  ();

  issue_ctrl #(.NREG(32), .AW(5), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  issue_ctrl #(.NREG(32), .AW(5), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_rs1_ena = 0; bus.id_rs1_addr = 0; bus.id_rs2_ena = 0;
    bus.id_rs2_addr = 0; bus.id_rd_ena = 0; bus.id_rd_addr = 0; bus.id_is_bj = 0;
    bus.id_is_term = 0; bus.mem_busy = 0; bus.wb_valid = 0; bus.wb_rd_addr = 0;
    bus.ex_bj_valid = 0; bus.ex_bj_taken = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    b4.id_valid = 0; b4.id_rs1_ena = 0; b4.id_rs1_addr = 0; b4.id_rs2_ena = 0;
    b4.id_rs2_addr = 0; b4.id_rd_ena = 0; b4.id_rd_addr = 0; b4.id_is_bj = 0;
    b4.id_is_term = 0; b4.mem_busy = 0; b4.wb_valid = 0; b4.wb_rd_addr = 0;
    b4.ex_bj_valid = 0; b4.ex_bj_taken = 0;

    // Reset state
    #3;
    check("rst_ready", bus.id_ready, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_halt", bus.halt, 0);
    check("rst_sb", bus.sb_pending, 0);
    check("rst_cnt", bus.stall_cnt, 0);
    check("rst_cnt4", b4.stall_cnt, 0);
    #5 rst_n = 1'b1;
    tick();

    // 1. RAW on x5 through writeback
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 5;
    #1 check("t1_wr_ready", bus.id_ready, 1);
    tick();
    bus.id_rd_ena = 0; bus.id_rs1_ena = 1; bus.id_rs1_addr = 5;
    #1 check("t1_sb5", bus.sb_pending, 64'h20);
    check("t1_stall_a", bus.id_ready, 0);
    tick();
    check("t1_cnt1", bus.stall_cnt, 1);
    check("t1_stall_b", bus.id_ready, 0);
    tick();
    bus.wb_valid = 1; bus.wb_rd_addr = 5;
    #1 check("t1_stall_wb", bus.id_ready, 0);
    tick();
    bus.wb_valid = 0;
    #1 check("t1_sb_clr", bus.sb_pending, 0);
    check("t1_ready_after", bus.id_ready, 1);
    check("t1_cnt3", bus.stall_cnt, 3);
    tick();
    idle_inputs();
    #1 check("t1_cnt_hold", bus.stall_cnt, 3);

    // 2. x0 never tracked
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 0;
    #1 check("t2_wr_ready", bus.id_ready, 1);
    tick();
    bus.id_rd_ena = 0; bus.id_rs1_ena = 1; bus.id_rs1_addr = 0;
    #1 check("t2_sb", bus.sb_pending, 0);
    check("t2_rd_ready", bus.id_ready, 1);
    tick();
    idle_inputs();
    #1 check("t2_cnt", bus.stall_cnt, 3);

    // 3. Branch taken, then not taken
    bus.ex_bj_valid = 1; bus.ex_bj_taken = 1;
    #1 check("t3_ex_in_run", bus.flush, 0);
    bus.ex_bj_valid = 0; bus.ex_bj_taken = 0;
    bus.id_valid = 1; bus.id_is_bj = 1;
    #1 check("t3_bj_ready", bus.id_ready, 1);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_wait_ready", bus.id_ready, 0);
      check("t3_wait_flush", bus.flush, 0);
      tick();
    end
    bus.ex_bj_valid = 1; bus.ex_bj_taken = 1;
    #1 check("t3_flush", bus.flush, 1);
    check("t3_flush_ready", bus.id_ready, 0);
    tick();
    bus.ex_bj_valid = 0; bus.ex_bj_taken = 0;
    #1 check("t3_flush_once", bus.flush, 0);
    check("t3_run_ready", bus.id_ready, 1);
    bus.id_valid = 1; bus.id_is_bj = 1;
    tick();
    idle_inputs();
    #1 check("t3_nt_wait", bus.id_ready, 0);
    tick();
    bus.ex_bj_valid = 1; bus.ex_bj_taken = 0;
    #1 check("t3_nt_flush", bus.flush, 0);
    tick();
    bus.ex_bj_valid = 0;
    #1 check("t3_nt_ready", bus.id_ready, 1);
    check("t3_cnt", bus.stall_cnt, 3);

    // 4. Set/clear priority
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 7;
    bus.wb_valid = 1; bus.wb_rd_addr = 7;
    #1 check("t4_ready", bus.id_ready, 1);
    tick();
    check("t4_set_wins", bus.sb_pending, 64'h80);
    bus.id_rd_addr = 9;
    #1 check("t4_ready9", bus.id_ready, 1);
    tick();
    check("t4_clr7_set9", bus.sb_pending, 64'h200);
    bus.id_valid = 0; bus.id_rd_ena = 0; bus.wb_rd_addr = 4;
    tick();
    check("t4_clr_nonpend", bus.sb_pending, 64'h200);
    bus.wb_rd_addr = 9;
    tick();
    idle_inputs();
    #1 check("t4_clr9", bus.sb_pending, 0);

    // 5. Drain and halt
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 3;
    tick();
    bus.id_rd_ena = 0; bus.id_rs2_ena = 1; bus.id_rs2_addr = 3;
    #1 check("t5_rs2_haz", bus.id_ready, 0);
    bus.id_rs2_ena = 0; bus.id_rd_ena = 1;
    #1 check("t5_waw_haz", bus.id_ready, 0);
    bus.id_rd_ena = 0; bus.mem_busy = 1;
    #1 check("t5_membusy", bus.id_ready, 0);
    bus.mem_busy = 0; bus.id_is_term = 1; bus.id_is_bj = 1;
    #1 check("t5_term_ready", bus.id_ready, 1);
    tick();
    bus.id_is_term = 0; bus.id_is_bj = 0; bus.mem_busy = 1;
    #1 check("t5_drain_ready", bus.id_ready, 0);
    tick();
    check("t5_nohalt_a", bus.halt, 0);
    bus.wb_valid = 1; bus.wb_rd_addr = 3;
    tick();
    bus.wb_valid = 0;
    #1 check("t5_sb_empty", bus.sb_pending, 0);
    check("t5_nohalt_b", bus.halt, 0);
    tick();
    check("t5_nohalt_c", bus.halt, 0);
    bus.mem_busy = 0;
    tick();
    check("t5_halt", bus.halt, 1);
    check("t5_halt_ready", bus.id_ready, 0);
    tick();
    tick();
    check("t5_halt_sticky", bus.halt, 1);
    check("t5_cnt", bus.stall_cnt, 3);

    // 6a. Reset mid-BR_WAIT
    rst_n = 1'b0;
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();
    check("t6_out_of_halt", bus.halt, 0);
    bus.id_valid = 1; bus.id_is_bj = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 6;
    tick();
    idle_inputs();
    bus.id_valid = 1; bus.ex_bj_valid = 1; bus.ex_bj_taken = 1;
    #1 check("t6_pre_sb", bus.sb_pending, 64'h40);
    check("t6_pre_flush", bus.flush, 1);
    #1 rst_n = 1'b0;
    #1 check("t6_rst_flush", bus.flush, 0);
    check("t6_rst_ready", bus.id_ready, 0);
    check("t6_rst_halt", bus.halt, 0);
    check("t6_rst_sb", bus.sb_pending, 0);
    check("t6_rst_cnt", bus.stall_cnt, 0);
    #1 rst_n = 1'b1;
    bus.ex_bj_valid = 0; bus.ex_bj_taken = 0;
    #1 check("t6_run_ready", bus.id_ready, 1);
    tick();
    idle_inputs();

    // 6b. Saturation on the 4-bit counter instance
    b4.id_valid = 1; b4.mem_busy = 1;
    for (int i = 0; i < 14; i++) tick();
    check("t6_cnt14", b4.stall_cnt, 14);
    check("t6_b4_ready", b4.id_ready, 0);
    tick();
    check("t6_cnt15", b4.stall_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    check("t6_cnt_sat", b4.stall_cnt, 15);
    b4.id_valid = 0; b4.mem_busy = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
